pc_sequencer: RTL

//  Owns the 8-bit program counter and consumes the PC+1 value to choose the next fetch address.

---
 rtl/pc_sequencer_pkg.sv | 36 +++
 rtl/pc_sequencer_ras_stack.sv | 79 +++++++
 rtl/pc_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared constants and encodings for the program-counter sequencer.
package pc_sequencer_pkg;

    localparam int unsigned PC_W      = 8;
    localparam int unsigned RAS_DEPTH = 4;
    localparam int unsigned RESET_PC  = 0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_t;

    // Selected source of the next fetch address
    typedef enum logic [2:0] {
        SRC_HOLD = 3'd0,
        SRC_SEQ  = 3'd1,
        SRC_BR   = 3'd2,
        SRC_CALL = 3'd3,
        SRC_RET  = 3'd4
    } pc_src_t;

    function automatic pc_src_t sel_src(input logic adv, input logic ret,
                                        input logic ras_empty, input logic call,
                                        input logic br_taken);
        pc_src_t src;
        src = SRC_HOLD;
        if (adv) begin
            if (ret)           src = ras_empty ? SRC_SEQ : SRC_RET;
            else if (call)     src = SRC_CALL;
            else if (br_taken) src = SRC_BR;
            else               src = SRC_SEQ;
        end
        return src;
    endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address LIFO: a full push overwrites the oldest entry.
module ras_stack
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH,
    parameter int unsigned W     = PC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         ovf,
    output logic         unf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_ovf;
    logic             r_unf;

    logic             w_do_push;
    logic             w_do_pop;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_do_pop  = pop & ~r_empty;
    assign w_do_push = push & ~pop;

    // Count saturates at DEPTH; the pointer keeps wrapping
    always_comb begin
        w_count_nxt = r_count;
        if (w_do_pop)
            w_count_nxt = r_count - CNT_W'(1);
        else if (w_do_push && !r_full)
            w_count_nxt = r_count + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top   <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_do_pop)
                r_top <= r_top - PTR_W'(1);
            else if (w_do_push)
                r_top <= r_top + PTR_W'(1);
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == CNT_W'(0));
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_ovf   <= w_do_push & r_full;
            r_unf   <= pop & r_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_top] <= din;
    end

    assign dout  = r_mem[r_top - PTR_W'(1)];
    assign empty = r_empty;
    assign full  = r_full;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with branch/call/return selection, return-address stack and RUN/HALT control.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned P_PC_W      = PC_W,
    parameter int unsigned P_RAS_DEPTH = RAS_DEPTH,
    parameter int unsigned P_RESET_PC  = RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              stall,
    input  logic              br_taken,
    input  logic              call,
    input  logic              ret,
    input  logic [P_PC_W-1:0] target,
    input  logic              halt,
    input  logic              resume,
    output logic [P_PC_W-1:0] pc,
    output logic [P_PC_W-1:0] pc_plus1,
    output logic              halted,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_unf
);

    seq_state_t        r_state;
    logic [P_PC_W-1:0] r_pc;

    logic              w_adv;
    logic              w_push;
    logic              w_pop;
    logic [P_PC_W-1:0] w_pc_plus1;
    logic [P_PC_W-1:0] w_ras_dout;
    logic              w_ras_empty;
    logic              w_ras_full;
    logic              w_ras_ovf;
    logic              w_ras_unf;
    pc_src_t           w_src;
    logic [P_PC_W-1:0] w_pc_nxt;

    assign w_adv      = en & ~stall & (r_state == ST_RUN);
    assign w_pop      = w_adv & ret;
    assign w_push     = w_adv & call & ~ret;
    assign w_pc_plus1 = r_pc + P_PC_W'(1);

    ras_stack #(
        .DEPTH (P_RAS_DEPTH),
        .W     (P_PC_W)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_plus1),
        .dout  (w_ras_dout),
        .empty (w_ras_empty),
        .full  (w_ras_full),
        .ovf   (w_ras_ovf),
        .unf   (w_ras_unf)
    );

    // Priority: ret > call > branch > sequential; a ret on an empty stack falls through to pc+1
    always_comb begin
        w_src    = sel_src(w_adv, ret, w_ras_empty, call, br_taken);
        w_pc_nxt = r_pc;
        case (w_src)
            SRC_SEQ:  w_pc_nxt = w_pc_plus1;
            SRC_BR:   w_pc_nxt = target;
            SRC_CALL: w_pc_nxt = target;
            SRC_RET:  w_pc_nxt = w_ras_dout;
            default:  w_pc_nxt = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_pc    <= P_PC_W'(P_RESET_PC);
        end else begin
            r_pc <= w_pc_nxt;
            case (r_state)
                ST_RUN:  if (w_adv && halt) r_state <= ST_HALT;
                ST_HALT: if (resume)        r_state <= ST_RUN;
                default:                    r_state <= ST_RUN;
            endcase
        end
    end

    assign pc        = r_pc;
    assign pc_plus1  = w_pc_plus1;
    assign halted    = (r_state == ST_HALT);
    assign ras_empty = w_ras_empty;
    assign ras_full  = w_ras_full;
    assign ras_ovf   = w_ras_ovf;
    assign ras_unf   = w_ras_unf;

endmodule
